// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter sharing one single-ported memory between the
//            instruction-fetch and load/store request ports.
//            Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  err
);

    localparam int         c_BE_W    = DATA_W / 8;
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY_IF = 2'd1;
    localparam logic [1:0] c_BUSY_D  = 2'd2;
    localparam logic       c_OWN_IF  = 1'b0;
    localparam logic       c_OWN_D   = 1'b1;

    logic [1:0]        r_state;
    logic              r_last_owner;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [c_BE_W-1:0] r_mem_be;
    logic              r_if_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_idle;
    logic w_busy;
    logic w_if_gnt;
    logic w_d_gnt;
    logic w_timeout;

    assign w_idle = (r_state == c_IDLE);
    assign w_busy = (r_state == c_BUSY_IF) || (r_state == c_BUSY_D);

    // Grants are gated by rst_n so nothing is offered while reset is asserted.
    assign w_if_gnt = rst_n && w_idle && if_req && (!d_req || (r_last_owner == c_OWN_D));
    assign w_d_gnt  = rst_n && w_idle && d_req  && (!if_req || (r_last_owner == c_OWN_IF));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;
    logic       r_err;

    // Abort fires on the cycle the counter would reach TIMEOUT; mem_ready wins.
    assign w_timeout = w_busy && !mem_ready && (r_cnt == c_TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_if_gnt || w_d_gnt)
                r_cnt <= 8'd0;
            else if (w_busy && !mem_ready)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_last_owner <= c_OWN_IF;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_if_rvalid  <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_if_gnt) begin
                        r_state      <= c_BUSY_IF;
                        r_last_owner <= c_OWN_IF;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= if_addr;
                        r_mem_wdata  <= '0;
                        r_mem_be     <= '1;
                    end else if (w_d_gnt) begin
                        r_state      <= c_BUSY_D;
                        r_last_owner <= c_OWN_D;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= d_we;
                        r_mem_addr   <= d_addr;
                        r_mem_wdata  <= d_wdata;
                        r_mem_be     <= d_be;
                    end
                end
                c_BUSY_IF, c_BUSY_D: begin
                    if (mem_ready || w_timeout) begin
                        r_state     <= c_IDLE;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_mem_be    <= '0;
                        if (r_state == c_BUSY_IF) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= mem_ready ? mem_rdata : '0;
                        end else begin
                            r_d_rvalid <= 1'b1;
                            // Stores leave the load-data register untouched.
                            if (!r_mem_we)
                                r_d_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Cycle-by-cycle vector bench for mem_port_arbiter, plus watchdog /
//            long-wait sequences selected by MEM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    typedef struct {
        string       nm;
        logic        rst_n, ir; logic [31:0] ia;
        logic        dr, dwe;   logic [31:0] da, dwd; logic [3:0] dbe;
        logic        rdy;       logic [31:0] rd;
        logic        eig, edg, eirv, edrv, emreq, emwe;
        logic [31:0] emaddr, emwd; logic [3:0] embe;
        logic [31:0] eird, edrd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic rs, logic ir, logic [31:0] ia,
                                logic dr, logic dwe, logic [31:0] da, logic [31:0] dwd,
                                logic [3:0] dbe, logic rdy, logic [31:0] rd,
                                logic eig, logic edg, logic eirv, logic edrv,
                                logic emreq, logic emwe, logic [31:0] emaddr,
                                logic [31:0] emwd, logic [3:0] embe,
                                logic [31:0] eird, logic [31:0] edrd);
        vec_t v;
        v.nm = nm; v.rst_n = rs; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe;
        v.da = da; v.dwd = dwd; v.dbe = dbe; v.rdy = rdy; v.rd = rd;
        v.eig = eig; v.edg = edg; v.eirv = eirv; v.edrv = edrv; v.emreq = emreq;
        v.emwe = emwe; v.emaddr = emaddr; v.emwd = emwd; v.embe = embe;
        v.eird = eird; v.edrd = edrd;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_ready = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        //          name            rs ir ia        dr we da        dwd           be    rdy rd
        //                          ig dg irv drv mreq mwe maddr    mwd           mbe   ird           drd
        vecs.push_back(mk("rst",          0,1,32'h0,   1,0,32'h200,32'h0,       4'hF, 0,32'h0,
                                          0,0,0,0, 0,0,32'h0,  32'h0,       4'h0, 32'h0,       32'h0));
        vecs.push_back(mk("tie1",         1,1,32'h0,   1,0,32'h200,32'h0,       4'hF, 0,32'h0,
                                          0,1,0,0, 0,0,32'h0,  32'h0,       4'h0, 32'h0,       32'h0));
        vecs.push_back(mk("tie1_busy",    1,1,32'h0,   0,0,32'h200,32'h0,       4'hF, 1,32'h11111111,
                                          0,0,0,0, 1,0,32'h200,32'h0,       4'hF, 32'h0,       32'h0));
        vecs.push_back(mk("tie2",         1,1,32'h0,   1,0,32'h200,32'h0,       4'hF, 0,32'h0,
                                          1,0,0,1, 0,0,32'h0,  32'h0,       4'h0, 32'h0,       32'h11111111));
        vecs.push_back(mk("tie2_busy",    1,1,32'h0,   1,0,32'h200,32'h0,       4'hF, 1,32'h22222222,
                                          0,0,0,0, 1,0,32'h0,  32'h0,       4'hF, 32'h0,       32'h11111111));
        vecs.push_back(mk("tie3",         1,1,32'h0,   1,0,32'h200,32'h0,       4'hF, 0,32'h0,
                                          0,1,1,0, 0,0,32'h0,  32'h0,       4'h0, 32'h22222222,32'h11111111));
        vecs.push_back(mk("tie3_busy",    1,1,32'h0,   1,0,32'h200,32'h0,       4'hF, 1,32'h33333333,
                                          0,0,0,0, 1,0,32'h200,32'h0,       4'hF, 32'h22222222,32'h11111111));
        vecs.push_back(mk("tie4",         1,1,32'h0,   1,0,32'h200,32'h0,       4'hF, 0,32'h0,
                                          1,0,0,1, 0,0,32'h0,  32'h0,       4'h0, 32'h22222222,32'h33333333));
        vecs.push_back(mk("tie4_busy",    1,0,32'h0,   0,0,32'h200,32'h0,       4'hF, 1,32'h44444444,
                                          0,0,0,0, 1,0,32'h0,  32'h0,       4'hF, 32'h22222222,32'h33333333));
        vecs.push_back(mk("tie4_done",    1,0,32'h0,   0,0,32'h0,  32'h0,       4'h0, 1,32'hFFFFFFFF,
                                          0,0,1,0, 0,0,32'h0,  32'h0,       4'h0, 32'h44444444,32'h33333333));
        vecs.push_back(mk("idle_ready",   1,0,32'h0,   0,0,32'h0,  32'h0,       4'h0, 1,32'hFFFFFFFF,
                                          0,0,0,0, 0,0,32'h0,  32'h0,       4'h0, 32'h44444444,32'h33333333));
        vecs.push_back(mk("fetch",        1,1,32'h100, 0,0,32'h0,  32'h0,       4'h0, 0,32'h0,
                                          1,0,0,0, 0,0,32'h0,  32'h0,       4'h0, 32'h44444444,32'h33333333));
        vecs.push_back(mk("fetch_busy",   1,0,32'h100, 0,0,32'h0,  32'h0,       4'h0, 1,32'h00500093,
                                          0,0,0,0, 1,0,32'h100,32'h0,       4'hF, 32'h44444444,32'h33333333));
        vecs.push_back(mk("fetch_done",   1,0,32'h0,   0,0,32'h0,  32'h0,       4'h0, 0,32'h0,
                                          0,0,1,0, 0,0,32'h0,  32'h0,       4'h0, 32'h00500093,32'h33333333));
        vecs.push_back(mk("store",        1,0,32'h0,   1,1,32'h300,32'hDEADBEEF,4'h3, 0,32'h0,
                                          0,1,0,0, 0,0,32'h0,  32'h0,       4'h0, 32'h00500093,32'h33333333));
        vecs.push_back(mk("store_w1",     1,1,32'h0,   0,1,32'h300,32'hDEADBEEF,4'h3, 0,32'h0,
                                          0,0,0,0, 1,1,32'h300,32'hDEADBEEF,4'h3, 32'h00500093,32'h33333333));
        vecs.push_back(mk("store_w2",     1,0,32'h0,   0,0,32'h0,  32'h0,       4'h0, 0,32'h0,
                                          0,0,0,0, 1,1,32'h300,32'hDEADBEEF,4'h3, 32'h00500093,32'h33333333));
        vecs.push_back(mk("store_w3",     1,0,32'h0,   0,0,32'h0,  32'h0,       4'h0, 0,32'h0,
                                          0,0,0,0, 1,1,32'h300,32'hDEADBEEF,4'h3, 32'h00500093,32'h33333333));
        vecs.push_back(mk("store_ready",  1,0,32'h0,   0,0,32'h0,  32'h0,       4'h0, 1,32'hCAFEF00D,
                                          0,0,0,0, 1,1,32'h300,32'hDEADBEEF,4'h3, 32'h00500093,32'h33333333));
        vecs.push_back(mk("store_done",   1,0,32'h0,   0,0,32'h0,  32'h0,       4'h0, 0,32'h0,
                                          0,0,0,1, 0,0,32'h0,  32'h0,       4'h0, 32'h00500093,32'h33333333));
        vecs.push_back(mk("after_store",  1,0,32'h0,   0,0,32'h0,  32'h0,       4'h0, 0,32'h0,
                                          0,0,0,0, 0,0,32'h0,  32'h0,       4'h0, 32'h00500093,32'h33333333));
        vecs.push_back(mk("load",         1,0,32'h0,   1,0,32'h400,32'h0,       4'hF, 0,32'h0,
                                          0,1,0,0, 0,0,32'h0,  32'h0,       4'h0, 32'h00500093,32'h33333333));
        vecs.push_back(mk("load_rereq",   1,0,32'h0,   1,0,32'h400,32'h0,       4'hF, 0,32'h0,
                                          0,0,0,0, 1,0,32'h400,32'h0,       4'hF, 32'h00500093,32'h33333333));
        vecs.push_back(mk("load_rst",     0,0,32'h0,   1,0,32'h400,32'h0,       4'hF, 0,32'h0,
                                          0,0,0,0, 1,0,32'h400,32'h0,       4'hF, 32'h00500093,32'h33333333));
        vecs.push_back(mk("post_rst",     1,0,32'h0,   0,0,32'h0,  32'h0,       4'h0, 0,32'h0,
                                          0,0,0,0, 0,0,32'h0,  32'h0,       4'h0, 32'h0,       32'h0));
        vecs.push_back(mk("rst_tie",      1,1,32'h0,   1,0,32'h500,32'h0,       4'hF, 0,32'h0,
                                          0,1,0,0, 0,0,32'h0,  32'h0,       4'h0, 32'h0,       32'h0));
        vecs.push_back(mk("rst_tie_busy", 1,0,32'h0,   0,0,32'h500,32'h0,       4'hF, 1,32'h00000055,
                                          0,0,0,0, 1,0,32'h500,32'h0,       4'hF, 32'h0,       32'h0));
        vecs.push_back(mk("rst_tie_done", 1,0,32'h0,   0,0,32'h0,  32'h0,       4'h0, 0,32'h0,
                                          0,0,0,1, 0,0,32'h0,  32'h0,       4'h0, 32'h0,       32'h00000055));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; if_req = vecs[i].ir; if_addr = vecs[i].ia;
            d_req = vecs[i].dr; d_we = vecs[i].dwe; d_addr = vecs[i].da;
            d_wdata = vecs[i].dwd; d_be = vecs[i].dbe;
            mem_ready = vecs[i].rdy; mem_rdata = vecs[i].rd;
            #1;
            chk({vecs[i].nm, ".if_gnt"},    32'(if_gnt),    32'(vecs[i].eig));
            chk({vecs[i].nm, ".d_gnt"},     32'(d_gnt),     32'(vecs[i].edg));
            chk({vecs[i].nm, ".if_rvalid"}, 32'(if_rvalid), 32'(vecs[i].eirv));
            chk({vecs[i].nm, ".d_rvalid"},  32'(d_rvalid),  32'(vecs[i].edrv));
            chk({vecs[i].nm, ".mem_req"},   32'(mem_req),   32'(vecs[i].emreq));
            chk({vecs[i].nm, ".mem_we"},    32'(mem_we),    32'(vecs[i].emwe));
            chk({vecs[i].nm, ".mem_addr"},  mem_addr,       vecs[i].emaddr);
            chk({vecs[i].nm, ".mem_wdata"}, mem_wdata,      vecs[i].emwd);
            chk({vecs[i].nm, ".mem_be"},    32'(mem_be),    32'(vecs[i].embe));
            chk({vecs[i].nm, ".if_rdata"},  if_rdata,       vecs[i].eird);
            chk({vecs[i].nm, ".d_rdata"},   d_rdata,        vecs[i].edrd);
            chk({vecs[i].nm, ".err"},       32'(err),       32'h0);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // Load that never completes: four BUSY cycles, then an error pulse.
        @(negedge clk);
        idle_inputs(); d_req = 1'b1; d_addr = 32'h600; d_be = 4'hF;
        #1 chk("to_gnt", 32'(d_gnt), 32'h1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_inputs();
            #1 chk("to_busy.mem_req", 32'(mem_req), 32'h1);
            chk("to_busy.err", 32'(err), 32'h0);
        end
        @(negedge clk);
        #1 chk("to_abort.mem_req", 32'(mem_req), 32'h0);
        chk("to_abort.d_rvalid", 32'(d_rvalid), 32'h1);
        chk("to_abort.err", 32'(err), 32'h1);
        chk("to_abort.d_rdata", d_rdata, 32'h0);

        // Same load, but mem_ready arrives in the 4th BUSY cycle.
        @(negedge clk);
        idle_inputs(); d_req = 1'b1; d_addr = 32'h640; d_be = 4'hF;
        #1 chk("to2_gnt", 32'(d_gnt), 32'h1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c == 3) begin mem_ready = 1'b1; mem_rdata = 32'h00000077; end
            #1 chk("to2_busy.mem_req", 32'(mem_req), 32'h1);
        end
        @(negedge clk);
        idle_inputs();
        #1 chk("to2_done.d_rvalid", 32'(d_rvalid), 32'h1);
        chk("to2_done.err", 32'(err), 32'h0);
        chk("to2_done.d_rdata", d_rdata, 32'h00000077);
`else
        // Without the watchdog a load waits indefinitely for mem_ready.
        @(negedge clk);
        idle_inputs(); d_req = 1'b1; d_addr = 32'h700; d_be = 4'hF;
        #1 chk("wait_gnt", 32'(d_gnt), 32'h1);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            idle_inputs();
            #1 chk("wait.mem_req", 32'(mem_req), 32'h1);
            chk("wait.err", 32'(err), 32'h0);
        end
        @(negedge clk);
        idle_inputs(); mem_ready = 1'b1; mem_rdata = 32'h00000088;
        #1 chk("wait_last.mem_req", 32'(mem_req), 32'h1);
        @(negedge clk);
        idle_inputs();
        #1 chk("wait_done.d_rvalid", 32'(d_rvalid), 32'h1);
        chk("wait_done.d_rdata", d_rdata, 32'h00000088);
        chk("wait_done.err", 32'(err), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported memory between the instruction-fetch path and the load/store path of the RISC-V core. Each requester uses a req/gnt/rvalid handshake. A three-state FSM serialises accesses:
- Round-robin on ties, so neither requester starves.
- Variable-latency memory handshake (`mem_ready`).
- Optional watchdog that aborts hung transactions.

It sits between the fetch unit and load/store unit on one side, and the unified memory on the other.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte-enable width is `DATA_W/8`.
- `TIMEOUT`, default 15: cycles spent in a BUSY state without `mem_ready` before abort. Range 1..255. Used only with the watchdog.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in `ADDR_W`: fetch address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out `DATA_W`: fetched instruction.
- `d_req` in 1: data request; held until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in `ADDR_W`: data address.
- `d_wdata` in `DATA_W`: store data.
- `d_be` in `DATA_W/8`: byte enables.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: one-cycle pulse at completion of load or store.
- `d_rdata` out `DATA_W`: load data.
- `mem_req` out 1: memory access active.
- `mem_we` out 1: memory write.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_be` out `DATA_W/8`: memory byte enables.
- `mem_ready` in 1: memory completes the access this cycle.
- `mem_rdata` in `DATA_W`: memory read data, valid with `mem_ready`.
- `err` out 1: timeout abort pulse, coincident with `rvalid`.

## Operation
- **States:**
  - IDLE.
  - BUSY_IF.
  - BUSY_D.
- **`last_owner` register** (IF/D) records the most recent grant.
- **In IDLE** (grants are combinational from `req` and state):
  - Only `if_req` high: `if_gnt` = 1.
  - Only `d_req` high: `d_gnt` = 1.
  - Both high: grant the requester that is not `last_owner`.
  - Never both gnt in the same cycle.
- **On a granted edge:**
  - Latch the request into the address/wdata/be/we registers.
  - Update `last_owner`.
  - Go to BUSY_IF or BUSY_D.
- **Fetch requests** are latched as `mem_we` = 0, `mem_be` = all ones.
- **In BUSY_x:**
  - `mem_req` = 1 and the latched fields drive the `mem_*` outputs.
  - Both gnt = 0.
  - On a cycle with `mem_ready` = 1:
    - Register `mem_rdata` into `x_rdata` for fetches and loads only; stores leave `d_rdata` unchanged.
    - Pulse `x_rvalid` in the next cycle.
    - Return to IDLE.
- **Outside BUSY**, the `mem_*` outputs are 0.
- **Timeout counter:**
  - 8-bit, cleared on entering BUSY, increments each BUSY cycle without `mem_ready`.
- **Boundary cases:**
  - `req` dropped before gnt: no transaction.
  - Requester re-requests while its transaction is outstanding: waits; no gnt until IDLE.
  - `mem_ready` outside BUSY: ignored.
  - `mem_ready` and timeout expiry in the same cycle: `mem_ready` wins; normal completion, `err` = 0.
  - Reset mid-transaction: transaction dropped, no `rvalid`, FSM to IDLE.

## Timing
- **Reset values:**
  - State = IDLE, `last_owner` = IF, so the first tie goes to D.
  - Counter = 0.
  - All outputs 0, including `if_rdata` and `d_rdata`.
- **Minimum latency** (req in cycle 0):
  - gnt in cycle 0.
  - `mem_req` in cycle 1.
  - `mem_ready` in cycle 1 gives `rvalid` in cycle 2.
- **Throughput:** at most one transaction per 2 cycles, because IDLE always takes one cycle between accesses.
- **Next grant:** occurs in the same cycle as the `rvalid` pulse (that cycle is IDLE).

## Configuration
- **`MEM_ARB_TIMEOUT_EN` defined:** if the counter reaches `TIMEOUT` in BUSY:
  - Drop `mem_req`.
  - Return to IDLE.
  - Next cycle, pulse the owner's `rvalid` with `err` = 1 and `rdata` forced to 0 (fetch and load).
- **Undefined:**
  - No counter logic.
  - BUSY waits for `mem_ready` indefinitely.
  - `err` tied to 0.

## Test plan
- **Single fetch:** `if_req`, `if_addr` = 0x100; `mem_ready` with `mem_rdata` = 0x00500093 in cycle 1. Expect:
  - `if_gnt` in cycle 0.
  - `mem_addr` = 0x100, `mem_be` = 0xF in cycle 1.
  - `if_rvalid` with `if_rdata` = 0x00500093 in cycle 2.
- **Tie after reset:** both req high, `d_addr` = 0x200, `if_addr` = 0x0. Expect:
  - `d_gnt` first.
  - `if_gnt` in the IDLE cycle after `d_rvalid`.
  - Continuous ties alternate D, IF, D, IF.
- **Store with wait states:** `d_we` = 1, `d_be` = 0x3, `d_wdata` = 0xDEADBEEF, `mem_ready` after 3 wait cycles. Expect:
  - `mem_we`/`mem_be`/`mem_wdata` stable all 4 BUSY cycles.
  - `d_rvalid` pulse; `d_rdata` unchanged.
- **Reset mid-op:** `rst_n` low in the second BUSY_D cycle. Expect:
  - Next cycle all outputs 0.
  - No `d_rvalid`.
  - Next tie granted to D.
- **Timeout (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT` = 4):** load with `mem_ready` never asserted. Expect:
  - `mem_req` high exactly 4 cycles.
  - Then `d_rvalid` = 1, `err` = 1, `d_rdata` = 0.
  - Repeat with `mem_ready` in the 4th cycle: normal data, `err` = 0.
- **Without the macro:** `mem_ready` held low for 100 cycles. Expect `mem_req` held high throughout and `err` = 0.
